// File: rtl/param_data_memory.sv
// param_data_memory: single-port byte-lane-writable data memory with optional zero-fill sweep.
// Latency: reads return registered data one cycle after acceptance; writes take effect at the accepting edge.
// Backpressure: req_ready drops while a sweep runs; responses are never back-pressured.
//
// Optional feature macro: DMEM_CLEAR_EN (compiles in the zero-fill sweep; after reset and on clr_start
// the block spends DEPTH cycles writing zeros before accepting requests).
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   req_valid / req_ready request handshake; one request per cycle at most
//   req_write             1 = write, 0 = read
//   req_addr              word address
//   req_wdata / req_be    write data and per-byte lane enables (bit i -> bits [8i+7:8i])
//   rsp_valid / rsp_rdata one-cycle read response; rsp_rdata holds between responses
//   clr_start             pulse requesting a zero-fill sweep (ignored during a sweep / when compiled out)
//   busy                  sweep in progress
module param_data_memory #(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 5,
   localparam int LANES  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [LANES-1:0]  req_be,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   input  logic              clr_start,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              req_acc;
   logic              sweep_we;
   logic [ADDR_W-1:0] sweep_addr;

   assign req_acc = req_valid && req_ready;

`ifdef DMEM_CLEAR_EN
   logic [ADDR_W-1:0] cnt;

   // req_ready/busy are registered alongside the state so they change on the
   // same edge the FSM moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLEAR;
         cnt       <= '0;
         req_ready <= 1'b0;
         busy      <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               // Last word is zeroed on this same edge, so a sweep is exactly DEPTH cycles.
               if (cnt == '1) begin
                  cnt       <= '0;
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE: begin
               // A request accepted this cycle still completes; the sweep starts next edge.
               if (clr_start) begin
                  state     <= CLEAR;
                  cnt       <= '0;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            default: begin
               state     <= CLEAR;
               cnt       <= '0;
               req_ready <= 1'b0;
               busy      <= 1'b1;
            end
         endcase
      end
   end

   // Gating with rst_n keeps the storage untouched while reset is held.
   assign sweep_we   = (state == CLEAR) && rst_n;
   assign sweep_addr = cnt;
`else
   logic unused_clr_start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLEAR;
         req_ready <= 1'b0;
      end else begin
         state     <= IDLE;
         req_ready <= 1'b1;
      end
   end

   assign busy             = 1'b0;
   assign sweep_we         = 1'b0;
   assign sweep_addr       = '0;
   assign unused_clr_start = clr_start ^ (state == IDLE);
`endif

   // Storage has no reset. Sweep writes and request writes never coincide
   // because req_ready is low for the whole sweep.
   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem[sweep_addr] <= '0;
      end else if (req_acc && req_write) begin
         for (int i = 0; i < LANES; i++) begin
            if (req_be[i]) begin
               mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

   // Read data is captured at the accepting edge, before any sweep that
   // begins on the following edge can touch it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= req_acc && !req_write;
         if (req_acc && !req_write) begin
            rsp_rdata <= mem[req_addr];
         end
      end
   end

endmodule
